// File: rtl/byte_mul_sequencer.sv
// Byte-serial 32x32 unsigned multiplier: one 8x32 partial product per cycle.
// Optional BYTE_MUL_ZERO_SKIP_EN ends the sequence early once the remaining multiplier bytes are zero.
module rotate_left (
    input  logic [31:0] operand_i,
    input  logic [1:0]  rol_amount_i,
    output logic [31:0] result_o
);

    always_comb begin
        unique case (rol_amount_i)
            2'd0: result_o = operand_i;
            2'd1: result_o = {operand_i[23:0], operand_i[31:24]};
            2'd2: result_o = {operand_i[15:0], operand_i[31:16]};
            2'd3: result_o = {operand_i[7:0],  operand_i[31:8]};
            default: result_o = operand_i;
        endcase
    end

endmodule

module byte_mul_sequencer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        op_hi_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    input  logic        ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [1:0]  k;
    logic [1:0]  k_n;
    logic [63:0] acc;
    logic [63:0] acc_n;
    logic [31:0] opa;
    logic [31:0] opa_n;
    logic [31:0] opb;
    logic [31:0] opb_n;
    logic        hi;
    logic        hi_n;

    logic [1:0]  rol_amount;
    logic [31:0] rotated;
    logic [7:0]  mul_byte;
    logic [39:0] partial;
    logic [63:0] partial_shifted;
    logic        last;
    logic        unused_upper;

    // Rotating by (4-k) bytes brings multiplier byte k down to bits [7:0].
    assign rol_amount = 2'd0 - k;

    rotate_left u_rol (
        .operand_i    (opb),
        .rol_amount_i (rol_amount),
        .result_o     (rotated)
    );

    assign mul_byte        = rotated[7:0];
    assign partial         = {8'd0, opa} * {32'd0, mul_byte};
    assign partial_shifted = {24'd0, partial} << {k, 3'b000};
    assign unused_upper    = ^rotated[31:8];

`ifdef BYTE_MUL_ZERO_SKIP_EN
    logic upper_zero;

    // After rotation the bytes above k sit directly above bits [7:0].
    always_comb begin
        unique case (k)
            2'd0: upper_zero = (rotated[31:8] == 24'd0);
            2'd1: upper_zero = (rotated[23:8] == 16'd0);
            2'd2: upper_zero = (rotated[15:8] == 8'd0);
            2'd3: upper_zero = 1'b1;
            default: upper_zero = 1'b1;
        endcase
    end

    assign last = (k == 2'd3) || upper_zero;
`else
    assign last = (k == 2'd3);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            k     <= 2'd0;
            acc   <= 64'd0;
            opa   <= 32'd0;
            opb   <= 32'd0;
            hi    <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            acc   <= acc_n;
            opa   <= opa_n;
            opb   <= opb_n;
            hi    <= hi_n;
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        acc_n   = acc;
        opa_n   = opa;
        opb_n   = opb;
        hi_n    = hi;
        if (flush_i) begin
            state_n = IDLE;
            k_n     = 2'd0;
            acc_n   = 64'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        opa_n   = operand_a_i;
                        opb_n   = operand_b_i;
                        hi_n    = op_hi_i;
                        acc_n   = 64'd0;
                        k_n     = 2'd0;
                        state_n = BUSY;
                    end
                end
                BUSY: begin
                    acc_n = acc + partial_shifted;
                    k_n   = k + 2'd1;
                    if (last) begin
                        k_n     = 2'd0;
                        state_n = DONE;
                    end
                end
                DONE: begin
                    if (ack_i) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    k_n     = 2'd0;
                    acc_n   = 64'd0;
                end
            endcase
        end
    end

    assign ready_o  = (state == IDLE);
    assign valid_o  = (state == DONE);
    assign result_o = !valid_o ? 32'd0 : (hi ? acc[63:32] : acc[31:0]);

endmodule

// File: tb/tb_byte_mul_sequencer.sv
// Directed bench for byte_mul_sequencer with a result scoreboard.
module tb_byte_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        op_hi_i;
    logic        flush_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        ack_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    byte_mul_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .op_hi_i     (op_hi_i),
        .flush_i     (flush_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .ack_i       (ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic h);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return h ? p[63:32] : p[31:0];
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef BYTE_MUL_ZERO_SKIP_EN
        if (b[31:24] != 8'd0) return 4;
        if (b[23:16] != 8'd0) return 3;
        if (b[15:8] != 8'd0) return 2;
        return 1;
`else
        return 4;
`endif
    endfunction

    // Called at a negedge while idle; returns at the negedge after acceptance.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic h);
        start_i     = 1'b1;
        operand_a_i = a;
        operand_b_i = b;
        op_hi_i     = h;
        sb.push_back(model(a, b, h));
        @(posedge clk);
        @(negedge clk);
        start_i     = 1'b0;
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        op_hi_i     = ~h;
    endtask

    task automatic wait_result(input string tag, input int lat, output logic [31:0] exp);
        int cycles;
        logic [1:0] rol;
        cycles = 0;
        while (valid_o !== 1'b1 && cycles < 20) begin
            if (cycles < 4) begin
                rol = 2'(4 - cycles);
                check({tag, " rol"}, {62'd0, dut.rol_amount}, {62'd0, rol});
            end
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(cycles), 64'(lat));
        check({tag, " valid"}, {63'd0, valid_o}, 64'd1);
        if (sb.size() == 0) begin
            exp = 32'd0;
            check({tag, " scoreboard"}, 64'd0, 64'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, " result"}, {32'd0, result_o}, {32'd0, exp});
        end
    endtask

    task automatic ack_result(input string tag);
        ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ack_i = 1'b0;
        check({tag, " ready after ack"}, {63'd0, ready_o}, 64'd1);
        check({tag, " result idle"}, {32'd0, result_o}, 64'd0);
    endtask

    task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic h);
        logic [31:0] e;
        start_op(a, b, h);
        wait_result(tag, exp_lat(b), e);
        ack_result(tag);
    endtask

    initial begin
        logic [31:0] e;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        operand_a_i = 32'd0;
        operand_b_i = 32'd0;
        op_hi_i     = 1'b0;
        flush_i     = 1'b0;
        ack_i       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ready", {63'd0, ready_o}, 64'd1);
        check("reset valid", {63'd0, valid_o}, 64'd0);
        check("reset result", {32'd0, result_o}, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        full_op("ex1 lo", 32'hAACC00FF, 32'h00000002, 1'b0);
        full_op("ex1 hi", 32'hAACC00FF, 32'h00000002, 1'b1);
        full_op("ones lo", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        full_op("ones hi", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        full_op("p16 lo", 32'h00010000, 32'h00010000, 1'b0);
        full_op("p16 hi", 32'h00010000, 32'h00010000, 1'b1);
        full_op("mixed", 32'h12345678, 32'h00C30000, 1'b1);

        // Hold the result without ack, then ack together with a new start.
        start_op(32'hDEADBEEF, 32'h0000A5A5, 1'b0);
        wait_result("hold", exp_lat(32'h0000A5A5), e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold valid", {63'd0, valid_o}, 64'd1);
            check("hold result", {32'd0, result_o}, {32'd0, e});
        end
        ack_i       = 1'b1;
        start_i     = 1'b1;
        operand_a_i = 32'd7;
        operand_b_i = 32'd9;
        op_hi_i     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ack_i = 1'b0;
        check("ack+start ready", {63'd0, ready_o}, 64'd1);
        check("ack+start valid", {63'd0, valid_o}, 64'd0);
        sb.push_back(model(32'd7, 32'd9, 1'b0));
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        check("restart accepted", {63'd0, ready_o}, 64'd0);
        wait_result("restart", exp_lat(32'd9), e);
        ack_result("restart");

        // Flush on E2 of BUSY.
        start_op(32'hFFFF0000, 32'hFF000001, 1'b1);
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        check("pre-flush valid", {63'd0, valid_o}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        void'(sb.pop_back());
        check("flush ready", {63'd0, ready_o}, 64'd1);
        check("flush valid", {63'd0, valid_o}, 64'd0);
        check("flush acc", dut.acc, 64'd0);
        // Flush wins over start in the same cycle.
        flush_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        start_i = 1'b0;
        check("flush over start", {63'd0, ready_o}, 64'd1);
        full_op("3x5", 32'd3, 32'd5, 1'b0);

        // Asynchronous reset mid-BUSY.
        start_op(32'h89ABCDEF, 32'h76543210, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        void'(sb.pop_back());
        check("async rst ready", {63'd0, ready_o}, 64'd1);
        check("async rst valid", {63'd0, valid_o}, 64'd0);
        check("async rst result", {32'd0, result_o}, 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        full_op("post rst", 32'h89ABCDEF, 32'h76543210, 1'b1);
        check("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

endmodule
